multicycle_main_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. It sequences fetch/decode/execute/memory/writeback
//  and drives every datapath enable, including the 3-bit ALUop consumed by the ALU control decoder.

---
 rtl/multicycle_main_control.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode, execute,
// memory and writeback, and drives every datapath enable plus the 3-bit ALUop.
module multicycle_main_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] function_code,
   input  logic       mem_ready,
   output logic [2:0] ALUop,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MEM_ADDR = 4'd3;
   localparam logic [3:0] S_MEM_RD   = 4'd4;
   localparam logic [3:0] S_MEM_WB   = 4'd5;
   localparam logic [3:0] S_MEM_WR   = 4'd6;
   localparam logic [3:0] S_R_EXEC   = 4'd7;
   localparam logic [3:0] S_R_WB     = 4'd8;
   localparam logic [3:0] S_I_EXEC   = 4'd9;
   localparam logic [3:0] S_I_WB     = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_JR       = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b100;
   localparam logic [2:0] ALU_FUNC = 3'b111;

   logic [3:0] state;
   logic [3:0] next_state;
   logic [5:0] op_q;
   logic [3:0] decode_target;
   logic       decode_illegal;

   // The funct field is fully resolved into the DECODE successor state (JR vs R_EXEC),
   // and the ALU control decoder reads it straight from IR, so only the opcode is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         op_q  <= 6'd0;
      end else begin
         state <= next_state;
         if (state == S_DECODE) op_q <= opcode;
      end
   end

   always_comb begin
      decode_target  = S_FETCH;
      decode_illegal = 1'b0;
      case (opcode)
         OP_LW, OP_SW: decode_target = S_MEM_ADDR;
         OP_RTYPE: begin
            case (function_code)
               FN_JR:                                  decode_target = S_JR;
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  decode_target = S_R_EXEC;
               default:                                decode_illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_target = S_I_EXEC;
         OP_BEQ:  decode_target = S_BRANCH;
         OP_J:    decode_target = S_JUMP;
         default: decode_illegal = 1'b1;
      endcase
   end

   // Memory handshake: mem_read/mem_write stay asserted in their state until mem_ready
   // is seen high on a rising edge; that edge both completes the access and advances the FSM.
   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE:     next_state = S_FETCH;
         S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   next_state = decode_target;
         S_MEM_ADDR: next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   next_state = S_R_WB;
         S_I_EXEC:   next_state = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: next_state = S_FETCH;
         default:    next_state = S_IDLE;
      endcase
   end

   always_comb begin
      ALUop         = 3'b000;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ALUop     = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            ALUop     = ALU_ADD;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ALUop     = ALU_ADD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            ALUop     = ALU_FUNC;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (op_q)
               OP_ANDI: ALUop = ALU_AND;
               OP_ORI:  ALUop = ALU_OR;
               OP_SLTI: ALUop = ALU_SLT;
               default: ALUop = ALU_ADD;
            endcase
         end
         S_I_WB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            ALUop         = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_JR: begin
            alu_src_a = 1'b1;
            ALUop     = ALU_FUNC;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

   assign illegal_op = (state == S_DECODE) && decode_illegal;
   assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: per-instruction state/handshake plans feed an expected
// queue of per-cycle control words, popped and compared by a negedge monitor.
module tb_multicycle_main_control;

   localparam int W = 22;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
   localparam logic [5:0] F_JR = 6'b001000, F_ADD = 6'b100000, F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] function_code = 6'd0;
   logic       mem_ready = 1'b0;
   logic [2:0] ALUop;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
   logic       pc_write, pc_write_cond, illegal_op;
   logic [1:0] pc_source;
   logic [3:0] state_dbg;

   multicycle_main_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .function_code(function_code),
      .mem_ready(mem_ready), .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           plan_st[$];
   logic         plan_mr[$];
   logic         plan_ill[$];

   // Control word the datapath should see in a given state (field order matches monitor).
   function automatic logic [W-1:0] ctrl(input logic [3:0] st, input logic [5:0] op,
                                         input logic mr, input logic ill);
      logic [2:0] aluop = 3'b000;
      logic       sa = 1'b0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic       io = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0, rw = 1'b0;
      logic       rd = 1'b0, m2r = 1'b0, pw = 1'b0, pwc = 1'b0;
      case (st)
         4'd1:  begin mrd = 1'b1; sb = 2'b01; aluop = 3'b101; irw = mr; pw = mr; end
         4'd2:  begin sb = 2'b11; aluop = 3'b101; end
         4'd3:  begin sa = 1'b1; sb = 2'b10; aluop = 3'b101; end
         4'd4:  begin mrd = 1'b1; io = 1'b1; end
         4'd5:  begin rw = 1'b1; m2r = 1'b1; end
         4'd6:  begin mwr = 1'b1; io = 1'b1; end
         4'd7:  begin sa = 1'b1; aluop = 3'b111; end
         4'd8:  begin rw = 1'b1; rd = 1'b1; end
         4'd9:  begin
            sa = 1'b1; sb = 2'b10;
            aluop = (op == ANDI) ? 3'b000 : (op == ORI) ? 3'b001 : (op == SLTI) ? 3'b100 : 3'b101;
         end
         4'd10: rw = 1'b1;
         4'd11: begin sa = 1'b1; aluop = 3'b110; pwc = 1'b1; ps = 2'b01; end
         4'd12: begin pw = 1'b1; ps = 2'b10; end
         4'd13: begin sa = 1'b1; aluop = 3'b111; pw = 1'b1; end
         default: ;
      endcase
      return {st, aluop, sa, sb, io, mrd, mwr, irw, rw, rd, m2r, pw, pwc, ps, ill};
   endfunction

   task automatic add_step(input int st, input logic mr, input logic ill);
      plan_st.push_back(st);
      plan_mr.push_back(mr);
      plan_ill.push_back(ill);
   endtask

   // Build the cycle plan for one instruction from its class, then drive it.
   // fw/mw: number of cycles mem_ready is held low in fetch / data access. limit>0 truncates.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input int limit);
      int n;
      plan_st.delete(); plan_mr.delete(); plan_ill.delete();
      for (int i = 0; i < fw; i++) add_step(1, 1'b0, 1'b0);
      add_step(1, 1'b1, 1'b0);
      if (op == LW || op == SW) begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b0);
         add_step(3, 1'($urandom_range(0, 1)), 1'b0);
         for (int i = 0; i < mw; i++) add_step((op == LW) ? 4 : 6, 1'b0, 1'b0);
         add_step((op == LW) ? 4 : 6, 1'b1, 1'b0);
         if (op == LW) add_step(5, 1'($urandom_range(0, 1)), 1'b0);
      end else if (op == RT && fn == F_JR) begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b0);
         add_step(13, 1'($urandom_range(0, 1)), 1'b0);
      end else if (op == RT && (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT})) begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b0);
         add_step(7, 1'($urandom_range(0, 1)), 1'b0);
         add_step(8, 1'($urandom_range(0, 1)), 1'b0);
      end else if (op inside {ADDI, ANDI, ORI, SLTI}) begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b0);
         add_step(9, 1'($urandom_range(0, 1)), 1'b0);
         add_step(10, 1'($urandom_range(0, 1)), 1'b0);
      end else if (op == BEQ) begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b0);
         add_step(11, 1'($urandom_range(0, 1)), 1'b0);
      end else if (op == JMP) begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b0);
         add_step(12, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
         add_step(2, 1'($urandom_range(0, 1)), 1'b1);
      end
      n = (limit > 0 && limit < plan_st.size()) ? limit : plan_st.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset     = 1'b0;
         mem_ready = plan_mr[i];
         // Opcode/funct are garbage outside DECODE; the FSM must ignore them there.
         opcode        = (plan_st[i] == 2) ? op : 6'($urandom);
         function_code = (plan_st[i] == 2) ? fn : 6'($urandom);
         exp_q.push_back(ctrl(4'(plan_st[i]), op, plan_mr[i], plan_ill[i]));
      end
   endtask

   // Hold reset for n cycles (all outputs 0), then one released cycle still in IDLE.
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         reset = 1'b1; mem_ready = 1'b0; opcode = 6'($urandom);
         exp_q.push_back('0);
      end
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] act, exp_w;
      act = {state_dbg, ALUop, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
             reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_source, illegal_op};
      if (exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         n_checks++;
         if (act === exp_w) n_pass++;
         else $display("FAIL ctrl_word t=%0t actual=%h required=%h (state actual=%0d required=%0d)",
                       $time, act, exp_w, state_dbg, exp_w[W-1 -: 4]);
      end
      n_checks++;
      if (!(mem_read && mem_write) && !(reg_write && (pc_write || pc_write_cond))) n_pass++;
      else $display("FAIL exclusive_strobes t=%0t actual mr=%b mw=%b rw=%b pw=%b pwc=%b required no overlap",
                    $time, mem_read, mem_write, reg_write, pc_write, pc_write_cond);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0] ops [10];
      logic [5:0] fns [6];
      logic [5:0] op, fn;
      ops = '{LW, SW, RT, RT, ADDI, ANDI, ORI, SLTI, BEQ, JMP};
      fns = '{F_JR, F_ADD, F_SUB, F_AND, F_OR, F_SLT};

      do_reset(3);
      run_instr(LW, 6'd0, 0, 0, 0);
      run_instr(RT, F_ADD, 0, 0, 0);
      run_instr(RT, F_JR, 0, 0, 0);
      run_instr(SW, 6'd0, 0, 3, 0);
      run_instr(6'b111111, 6'd0, 0, 0, 0);
      run_instr(RT, 6'b000111, 0, 0, 0);
      run_instr(ORI, 6'd0, 0, 0, 0);
      run_instr(BEQ, 6'd0, 0, 0, 0);
      run_instr(JMP, 6'd0, 0, 0, 0);
      run_instr(ADDI, 6'd0, 1, 0, 0);
      run_instr(ANDI, 6'd0, 0, 0, 0);
      run_instr(SLTI, 6'd0, 0, 0, 0);
      run_instr(LW, 6'd0, 2, 2, 0);

      // Abort a load while it waits in MEM_RD, then check it restarts cleanly at FETCH.
      run_instr(LW, 6'd0, 0, 5, 5);
      do_reset(1);
      run_instr(RT, F_SUB, 0, 0, 0);

      for (int k = 0; k < 80; k++) begin
         int a, b;
         a  = $urandom_range(0, 11);
         b  = $urandom_range(0, 7);
         op = (a < 10) ? ops[a] : 6'($urandom);
         fn = (b < 6) ? fns[b] : 6'($urandom);
         if (k % 23 == 22) begin
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4));
            do_reset($urandom_range(1, 2));
         end else begin
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 0);
         end
      end

      @(negedge clk); #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
